pc_fetch_unit: RTL and testbench

Sequential instruction-fetch front end for the LEGv8 datapath. Holds the architectural program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents the returned instruction to decode over a valid/ready handshake. The PC is loaded from the next-PC logic's `NextPC` output only when decode accepts the current instruction. This block is the consumer of the next-PC computation and the producer of `CurrentPC`.

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit_timeout_ctr.sv | 27 ++
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
// Used by pc_fetch_unit and fetch_timeout_ctr.
package pc_fetch_unit_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        ERROR = 2'd3
    } fetchState_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

endpackage

// File: rtl/pc_fetch_unit_timeout_ctr.sv
// Fetch watchdog: counts FETCH cycles without an ack and flags the
// last permitted cycle (count == TIMEOUT_CYCLES-1).
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic termCount
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 16'd1;
        end
    end

    assign termCount = (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential fetch front end: owns CurrentPC, one outstanding IMem request,
// registered instruction to decode. Optional counters under FETCH_PERF_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [PC_W-1:0]    NextPC,
    input  logic               Halt,
    output logic [PC_W-1:0]    CurrentPC,
    output logic               IMemReq,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic               FetchErr,
    output logic [1:0]         ErrCode,
`ifdef FETCH_PERF_EN
    output logic [31:0]        InstrCount,
    output logic [31:0]        StallCount,
`endif
    output logic [1:0]         DbgState
);

    // Handshakes: IMem transfer happens on an edge where IMemReq && IMemAck;
    // decode transfer on an edge where InstrValid && InstrReady. Neither
    // valid nor req drops before its transfer, and payloads hold meanwhile.

    fetchState_e          state, stateNext;
    logic [PC_W-1:0]      pcNext;
    logic [INSTR_W-1:0]   instrNext;
    logic [1:0]           errCodeNext;
    logic                 ctrClear, ctrInc, termCount;
    logic                 handshake;

    assign handshake = (state == ISSUE) && InstrValid && InstrReady;
    assign IMemAddr  = CurrentPC;
    assign DbgState  = state;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeout (
        .clk      (CLK),
        .rst      (Reset),
        .clear    (ctrClear),
        .incr     (ctrInc),
        .termCount(termCount)
    );

    always_comb begin
        stateNext   = state;
        pcNext      = CurrentPC;
        instrNext   = Instruction;
        errCodeNext = ErrCode;
        ctrClear    = 1'b0;
        ctrInc      = 1'b0;
        case (state)
            IDLE: begin
                if (CurrentPC[1:0] != 2'b00) begin
                    stateNext   = ERROR;
                    errCodeNext = ERR_MISALIGN;
                end else if (!Halt) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                // An ack on the terminal-count cycle still completes the fetch.
                if (IMemAck) begin
                    instrNext = IMemData;
                    ctrClear  = 1'b1;
                    stateNext = ISSUE;
                end else if (termCount) begin
                    stateNext   = ERROR;
                    errCodeNext = ERR_TIMEOUT;
                end else begin
                    ctrInc = 1'b1;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    // Misaligned target leaves PC on the offending branch.
                    if (NextPC[1:0] != 2'b00) begin
                        stateNext   = ERROR;
                        errCodeNext = ERR_MISALIGN;
                    end else begin
                        pcNext    = NextPC;
                        stateNext = Halt ? IDLE : FETCH;
                    end
                end
            end
            ERROR: begin
                stateNext = ERROR;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            CurrentPC   <= RESET_PC;
            Instruction <= '0;
            ErrCode     <= ERR_NONE;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b0;
            FetchErr    <= 1'b0;
        end else begin
            CurrentPC   <= pcNext;
            Instruction <= instrNext;
            ErrCode     <= errCodeNext;
            IMemReq     <= (stateNext == FETCH);
            InstrValid  <= (stateNext == ISSUE);
            FetchErr    <= (stateNext == ERROR);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            InstrCount <= '0;
            StallCount <= '0;
        end else if (state != ERROR) begin
            if (handshake && (InstrCount != 32'hFFFF_FFFF)) begin
                InstrCount <= InstrCount + 32'd1;
            end
            if ((state == FETCH) && !IMemAck && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit (TIMEOUT_CYCLES=4), plus a
// second instance with a misaligned RESET_PC and hand-written reset sequences.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] NextPC = '0;
    logic        Halt = 1'b0;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic        InstrReady = 1'b0;

    logic [63:0] CurrentPC, IMemAddr;
    logic        IMemReq, InstrValid, FetchErr;
    logic [31:0] Instruction;
    logic [1:0]  ErrCode, DbgState;

    logic [63:0] pc2, addr2;
    logic        req2, valid2, err2;
    logic [31:0] instr2;
    logic [1:0]  code2, dbg2;

`ifdef FETCH_PERF_EN
    logic [31:0] instrCount, stallCount, instrCount2, stallCount2;
`endif

    int nChecked = 0;
    int nFail = 0;

    always #5 CLK = ~CLK;

    pc_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT_CYCLES(4)) uDut (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Halt(Halt),
        .CurrentPC(CurrentPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(Instruction),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .FetchErr(FetchErr), .ErrCode(ErrCode),
`ifdef FETCH_PERF_EN
        .InstrCount(instrCount), .StallCount(stallCount),
`endif
        .DbgState(DbgState)
    );

    pc_fetch_unit #(.RESET_PC(64'h6), .TIMEOUT_CYCLES(4)) uDutMis (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Halt(Halt),
        .CurrentPC(pc2), .IMemReq(req2), .IMemAddr(addr2),
        .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(instr2),
        .InstrValid(valid2), .InstrReady(InstrReady),
        .FetchErr(err2), .ErrCode(code2),
`ifdef FETCH_PERF_EN
        .InstrCount(instrCount2), .StallCount(stallCount2),
`endif
        .DbgState(dbg2)
    );

    typedef struct {
        logic        halt;
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic [63:0] nextPc;
        logic [63:0] expPc;
        logic        expReq;
        logic        expValid;
        logic [31:0] expInstr;
        logic        expErr;
        logic [1:0]  expCode;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic halt, input logic ack, input logic [31:0] data,
                          input logic ready, input logic [63:0] nextPc,
                          input logic [63:0] expPc, input logic expReq, input logic expValid,
                          input logic [31:0] expInstr, input logic expErr, input logic [1:0] expCode);
        vec_t v;
        v.halt = halt; v.ack = ack; v.data = data; v.ready = ready; v.nextPc = nextPc;
        v.expPc = expPc; v.expReq = expReq; v.expValid = expValid;
        v.expInstr = expInstr; v.expErr = expErr; v.expCode = expCode;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecked++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [63:0] pc, input logic req,
                          input logic valid, input logic [31:0] instr,
                          input logic err, input logic [1:0] code);
        chk({tag, " CurrentPC"}, CurrentPC, pc);
        chk({tag, " IMemAddr"}, IMemAddr, pc);
        chk({tag, " IMemReq"}, 64'(IMemReq), 64'(req));
        chk({tag, " InstrValid"}, 64'(InstrValid), 64'(valid));
        chk({tag, " Instruction"}, 64'(Instruction), 64'(instr));
        chk({tag, " FetchErr"}, 64'(FetchErr), 64'(err));
        chk({tag, " ErrCode"}, 64'(ErrCode), 64'(code));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] I1 = 32'h8B02_0020, I2 = 32'hF840_0041, I3 = 32'hCB03_0062,
                            I4 = 32'hB400_0083, I5 = 32'h1111_0005, I6 = 32'h2222_0006,
                            I7 = 32'h3333_0007, I8 = 32'h4444_0008;

    initial begin
        // Main stream, timeout boundary, halt and error-stickiness vectors.
        addVec(0, 0, 0,  0, 0,        64'h0,   1, 0, 0,  0, 0);
        addVec(0, 1, I1, 0, 0,        64'h0,   0, 1, I1, 0, 0);
        addVec(0, 0, 0,  1, 64'h4,    64'h4,   1, 0, I1, 0, 0);
        addVec(0, 1, I2, 0, 0,        64'h4,   0, 1, I2, 0, 0);
        addVec(0, 0, 0,  1, 64'h8,    64'h8,   1, 0, I2, 0, 0);
        addVec(0, 1, I3, 0, 0,        64'h8,   0, 1, I3, 0, 0);
        addVec(0, 0, 0,  1, 64'hC,    64'hC,   1, 0, I3, 0, 0);
        addVec(0, 1, I4, 0, 0,        64'hC,   0, 1, I4, 0, 0);
        for (int i = 0; i < 5; i++)
            addVec(0, 1, 32'hDEAD_BEEF, 0, 64'h100, 64'hC, 0, 1, I4, 0, 0);
        addVec(0, 0, 0,  1, 64'h100,  64'h100, 1, 0, I4, 0, 0);
        addVec(0, 0, 0,  0, 0,        64'h100, 1, 0, I4, 0, 0);
        addVec(0, 1, I5, 0, 0,        64'h100, 0, 1, I5, 0, 0);
        addVec(1, 0, 0,  1, 64'h104,  64'h104, 0, 0, I5, 0, 0);
        addVec(1, 0, 0,  0, 0,        64'h104, 0, 0, I5, 0, 0);
        addVec(0, 0, 0,  0, 0,        64'h104, 1, 0, I5, 0, 0);
        addVec(1, 1, I6, 0, 0,        64'h104, 0, 1, I6, 0, 0);
        addVec(0, 0, 0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, I6, 0, 0);
        addVec(0, 1, I7, 0, 0,        64'hFFFF_FFFF_FFFF_FFFC, 0, 1, I7, 0, 0);
        addVec(0, 0, 0,  1, 64'h0,    64'h0,   1, 0, I7, 0, 0);
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, 0,     64'h0,   1, 0, I7, 0, 0);
        addVec(0, 1, I8, 0, 0,        64'h0,   0, 1, I8, 0, 0);
        addVec(0, 0, 0,  1, 64'h200,  64'h200, 1, 0, I8, 0, 0);
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, 0,     64'h200, 1, 0, I8, 0, 0);
        addVec(0, 0, 0,  0, 0,        64'h200, 0, 0, I8, 1, 2'b01);
        addVec(0, 1, I1, 1, 64'h300,  64'h200, 0, 0, I8, 1, 2'b01);
        addVec(0, 0, 0,  1, 64'h0,    64'h200, 0, 0, I8, 1, 2'b01);

        #12;
        chkAll("reset", 64'h0, 0, 0, 0, 0, 2'b00);
        chk("reset2 CurrentPC", pc2, 64'h6);
        chk("reset2 FetchErr", 64'(err2), 64'h0);

        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            Halt = vecs[i].halt; IMemAck = vecs[i].ack; IMemData = vecs[i].data;
            InstrReady = vecs[i].ready; NextPC = vecs[i].nextPc;
            step();
            chkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expReq, vecs[i].expValid,
                   vecs[i].expInstr, vecs[i].expErr, vecs[i].expCode);
        end

`ifdef FETCH_PERF_EN
        chk("perf InstrCount", 64'(instrCount), 64'd8);
        chk("perf StallCount", 64'(stallCount), 64'd8);
`endif
        // Misaligned RESET_PC instance went to ERROR from IDLE and stayed there.
        chk("mis CurrentPC", pc2, 64'h6);
        chk("mis FetchErr", 64'(err2), 64'h1);
        chk("mis ErrCode", 64'(code2), 64'h2);
        chk("mis IMemReq", 64'(req2), 64'h0);
        chk("mis InstrValid", 64'(valid2), 64'h0);

        // Asynchronous reset out of ERROR, mid-cycle.
        IMemAck = 0; InstrReady = 0; Halt = 0; NextPC = 0;
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1 chkAll("asyncRstErr", 64'h0, 0, 0, 0, 0, 2'b00);
        @(negedge CLK);
        Reset = 1'b0;
        step();
        chkAll("misFetch", 64'h0, 1, 0, 0, 0, 2'b00);
        IMemAck = 1; IMemData = I2;
        step();
        chkAll("misIssue", 64'h0, 0, 1, I2, 0, 2'b00);
        IMemAck = 0; InstrReady = 1; NextPC = 64'h102;
        step();
        chkAll("misTarget", 64'h0, 0, 0, I2, 1, 2'b10);
        InstrReady = 0; NextPC = 0;
        step();
        chkAll("misHold", 64'h0, 0, 0, I2, 1, 2'b10);

        // Reset while a fetch is in flight.
        @(negedge CLK);
        Reset = 1'b1;
        #1 chkAll("rstInErr", 64'h0, 0, 0, 0, 0, 2'b00);
        @(negedge CLK);
        Reset = 1'b0;
        step();
        chkAll("refetch", 64'h0, 1, 0, 0, 0, 2'b00);
        #2 Reset = 1'b1;
        #1 chkAll("rstMidFetch", 64'h0, 0, 0, 0, 0, 2'b00);
        chk("rstMidFetch state", 64'(DbgState), 64'h0);
        @(negedge CLK);
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFail);
        $finish;
    end

endmodule
